// File: rtl/adder_share_seq_pkg.sv
// Shared types and sizing for the nibble-serial shared-adder sequencer.
package adder_share_seq_pkg;
  localparam int OP_W  = 16;
  localparam int NIB_W = 4;
  localparam int NIB_N = 4;
  localparam int K_W   = $clog2(NIB_N);
  localparam logic [K_W-1:0] K_LAST = K_W'(NIB_N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPT,
    S_DONE
  } state_t;
endpackage

// File: rtl/adder_share_seq_if.sv
// Requester bus plus the link to the external registered 4-bit adder core.
interface adder_share_seq_if;
  import adder_share_seq_pkg::*;

  logic              req0;
  logic              req1;
  logic [OP_W-1:0]   a0;
  logic [OP_W-1:0]   b0;
  logic [OP_W-1:0]   a1;
  logic [OP_W-1:0]   b1;
  logic              cin0;
  logic              cin1;
  logic              ack0;
  logic              ack1;
  logic [OP_W-1:0]   res_sum;
  logic              res_cout;
  logic [NIB_W-1:0]  core_a;
  logic [NIB_W-1:0]  core_b;
  logic              core_cin;
  logic [NIB_W-1:0]  core_sum;
  logic              core_cout;

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    output core_sum, core_cout,
    input  ack0, ack1, res_sum, res_cout,
    input  core_a, core_b, core_cin
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  core_sum, core_cout,
    output ack0, ack1, res_sum, res_cout,
    output core_a, core_b, core_cin
  );
endinterface

// File: rtl/adder_share_seq_rr_arb2.sv
// Two-way round-robin arbiter; last-grant starts at 1 so requester 0 wins
// the first tie after reset.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_any,
  output logic o_gid
);
  logic r_last;

  assign o_any = i_req0 | i_req1;
  assign o_gid = (i_req0 & i_req1) ? ~r_last : i_req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_take) begin
      r_last <= o_gid;
    end
  end
endmodule

// File: rtl/adder_share_seq.sv
// Serialises 16-bit adds from two requesters onto one registered
// 4-bit adder core, one nibble per ISSUE/CAPT pair.
module adder_share_seq
  import adder_share_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             test_se,
  adder_share_seq_if.slave bus
);
  state_t          r_state;
  state_t          w_next;
  logic [K_W-1:0]  r_k;
  logic            r_carry;
  logic            r_cin;
  logic            r_id;
  logic [OP_W-1:0] r_a;
  logic [OP_W-1:0] r_b;
  logic [OP_W-1:0] r_acc;
  logic [OP_W-1:0] r_res_sum;
  logic            r_res_cout;
  logic            w_any;
  logic            w_gid;
  logic            w_take;
  logic            w_core_on;
  logic [3:0]      w_base;

  assign w_take = (r_state == S_IDLE) && w_any && !test_se;
  assign w_base = {r_k, 2'b00};

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req0 (bus.req0),
    .i_req1 (bus.req1),
    .i_take (w_take),
    .o_any  (w_any),
    .o_gid  (w_gid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Scan enable freezes the sequencer in whatever state it is in.
  always_comb begin
    w_next = r_state;
    if (!test_se) begin
      unique case (r_state)
        S_IDLE:  if (w_any) w_next = S_ISSUE;
        S_ISSUE: w_next = S_CAPT;
        S_CAPT:  w_next = (r_k == K_LAST) ? S_DONE : S_ISSUE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k        <= '0;
      r_carry    <= 1'b0;
      r_cin      <= 1'b0;
      r_id       <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_res_sum  <= '0;
      r_res_cout <= 1'b0;
    end else if (!test_se) begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id  <= w_gid;
            r_a   <= w_gid ? bus.a1 : bus.a0;
            r_b   <= w_gid ? bus.b1 : bus.b0;
            r_cin <= w_gid ? bus.cin1 : bus.cin0;
            r_k   <= '0;
          end
        end
        S_CAPT: begin
          r_acc[w_base +: NIB_W] <= bus.core_sum;
          r_carry <= bus.core_cout;
          if (r_k != K_LAST) r_k <= r_k + 1'b1;
        end
        S_DONE: begin
          r_res_sum  <= r_acc;
          r_res_cout <= r_carry;
        end
        default: ;
      endcase
    end
  end

  assign w_core_on = (r_state == S_ISSUE) || (r_state == S_CAPT);

  always_comb begin
    bus.core_a   = '0;
    bus.core_b   = '0;
    bus.core_cin = 1'b0;
    if (w_core_on) begin
      bus.core_a   = r_a[w_base +: NIB_W];
      bus.core_b   = r_b[w_base +: NIB_W];
      bus.core_cin = (r_k == '0) ? r_cin : r_carry;
    end
  end

  assign bus.ack0     = (r_state == S_DONE) && !test_se && !r_id;
  assign bus.ack1     = (r_state == S_DONE) && !test_se && r_id;
  assign bus.res_sum  = r_res_sum;
  assign bus.res_cout = r_res_cout;
endmodule

// File: tb/tb_adder_share_seq.sv
// Bench for adder_share_seq: registered 4-bit core model plus a
// plain-arithmetic reference for sums and round-robin grants.
module tb_adder_share_seq;
  import adder_share_seq_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic test_se = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_last = 1'b1;

  always #5 clk = ~clk;

  adder_share_seq_if bus();

  adder_share_seq dut (
    .clk     (clk),
    .rst     (rst),
    .test_se (test_se),
    .bus     (bus)
  );

  always @(posedge clk) begin
    {bus.core_cout, bus.core_sum} <=
      {1'b0, bus.core_a} + {1'b0, bus.core_b} + {4'd0, bus.core_cin};
  end

  function automatic logic [16:0] ref_add(logic [15:0] a, logic [15:0] b,
                                          logic c);
    return {1'b0, a} + {1'b0, b} + {16'd0, c};
  endfunction

  task automatic idle_bus();
    bus.req0 = 0; bus.req1 = 0;
    bus.a0 = 0; bus.b0 = 0; bus.cin0 = 0;
    bus.a1 = 0; bus.b1 = 0; bus.cin1 = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    exp_last = 1;
  endtask

  task automatic wait_ack(input int start, output int cyc,
                          output logic [1:0] g);
    cyc = -1;
    g = 2'b00;
    for (int i = start + 1; i <= start + 40; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        cyc = i;
        g = {bus.ack0, bus.ack1};
        break;
      end
    end
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ack: got %b want 00", {bus.ack0, bus.ack1});
    end
    n_chk++;
    if ({bus.res_cout, bus.res_sum} !== 17'd0) begin
      n_fail++; $display("FAIL reset_res: got %h want 0", {bus.res_cout, bus.res_sum});
    end
    n_chk++;
    if ({bus.core_a, bus.core_b, bus.core_cin} !== 9'd0) begin
      n_fail++; $display("FAIL reset_core: got %h want 0",
                         {bus.core_a, bus.core_b, bus.core_cin});
    end
    rst = 0;
    exp_last = 1;
    @(negedge clk);
  endtask

  task automatic test_single0();
    int cyc; logic [1:0] g;
    bus.a0 = 16'h1234; bus.b0 = 16'h0FCD; bus.cin0 = 0; bus.req0 = 1;
    wait_ack(0, cyc, g);
    bus.req0 = 0;
    exp_last = 0;
    n_chk++;
    if (cyc !== 9) begin n_fail++; $display("FAIL single0_lat: got %0d want 9", cyc); end
    n_chk++;
    if (g !== 2'b10) begin n_fail++; $display("FAIL single0_id: got %b want 10", g); end
    @(negedge clk);
    n_chk++;
    if ({bus.res_cout, bus.res_sum} !== {1'b0, 16'h2201}) begin
      n_fail++; $display("FAIL single0_res: got %h want 02201", {bus.res_cout, bus.res_sum});
    end
    n_chk++;
    if ({bus.ack0, bus.ack1} !== 2'b00) begin
      n_fail++; $display("FAIL single0_pulse: got %b want 00", {bus.ack0, bus.ack1});
    end
  endtask

  task automatic test_single1();
    int cyc; logic [1:0] g;
    bus.a1 = 16'hFFFF; bus.b1 = 16'h0001; bus.cin1 = 0; bus.req1 = 1;
    wait_ack(0, cyc, g);
    bus.req1 = 0;
    exp_last = 1;
    n_chk++;
    if (cyc !== 9 || g !== 2'b01) begin
      n_fail++; $display("FAIL single1_ack: got cyc %0d id %b want 9 01", cyc, g);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.res_cout, bus.res_sum} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL single1_res: got %h want 10000", {bus.res_cout, bus.res_sum});
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2; logic [1:0] g1, g2;
    do_reset();
    bus.a0 = 16'hFFFF; bus.b0 = 16'hFFFF; bus.cin0 = 1;
    bus.a1 = 16'hFFFF; bus.b1 = 16'hFFFF; bus.cin1 = 1;
    bus.req0 = 1; bus.req1 = 1;
    wait_ack(0, c1, g1);
    n_chk++;
    if (c1 !== 9 || g1 !== 2'b10) begin
      n_fail++; $display("FAIL tie_first: got cyc %0d id %b want 9 10", c1, g1);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.res_cout, bus.res_sum} !== 17'h1FFFF) begin
      n_fail++; $display("FAIL tie_res0: got %h want 1ffff", {bus.res_cout, bus.res_sum});
    end
    wait_ack(10, c2, g2);
    bus.req0 = 0; bus.req1 = 0;
    exp_last = 1;
    n_chk++;
    if (c2 !== 19 || g2 !== 2'b01) begin
      n_fail++; $display("FAIL tie_second: got cyc %0d id %b want 19 01", c2, g2);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.res_cout, bus.res_sum} !== 17'h1FFFF) begin
      n_fail++; $display("FAIL tie_res1: got %h want 1ffff", {bus.res_cout, bus.res_sum});
    end
  endtask

  task automatic test_scan_capt();
    int cyc; int acks; logic [1:0] g;
    acks = 0;
    bus.a0 = 16'h00FF; bus.b0 = 16'h0001; bus.cin0 = 0; bus.req0 = 1;
    repeat (6) @(negedge clk);
    bus.req0 = 0;
    test_se = 1;
    repeat (5) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks++;
    end
    n_chk++;
    if (acks !== 0) begin n_fail++; $display("FAIL scan_noack: got %0d acks want 0", acks); end
    n_chk++;
    if (bus.res_sum !== 16'hFFFF) begin
      n_fail++; $display("FAIL scan_hold: got %h want ffff", bus.res_sum);
    end
    test_se = 0;
    wait_ack(11, cyc, g);
    exp_last = 0;
    n_chk++;
    if (cyc !== 14 || g !== 2'b10) begin
      n_fail++; $display("FAIL scan_lat: got cyc %0d id %b want 14 10", cyc, g);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.res_cout, bus.res_sum} !== {1'b0, 16'h0100}) begin
      n_fail++; $display("FAIL scan_res: got %h want 00100", {bus.res_cout, bus.res_sum});
    end
  endtask

  task automatic test_scan_done();
    int cyc; int acks; logic [1:0] g; logic [16:0] e;
    acks = 0;
    e = ref_add(16'hABCD, 16'h1234, 1'b1);
    bus.a1 = 16'hABCD; bus.b1 = 16'h1234; bus.cin1 = 1; bus.req1 = 1;
    wait_ack(0, cyc, g);
    test_se = 1;
    #1;
    if (bus.ack0 || bus.ack1) acks++;
    repeat (3) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks++;
    end
    n_chk++;
    if (cyc !== 9 || acks !== 0) begin
      n_fail++; $display("FAIL sdone_frozen: got cyc %0d acks %0d want 9 0", cyc, acks);
    end
    n_chk++;
    if (bus.res_sum !== 16'h0100) begin
      n_fail++; $display("FAIL sdone_hold: got %h want 0100", bus.res_sum);
    end
    test_se = 0;
    #1;
    n_chk++;
    if ({bus.ack0, bus.ack1} !== 2'b01) begin
      n_fail++; $display("FAIL sdone_release: got %b want 01", {bus.ack0, bus.ack1});
    end
    bus.req1 = 0;
    exp_last = 1;
    @(negedge clk);
    n_chk++;
    if ({bus.res_cout, bus.res_sum} !== e) begin
      n_fail++; $display("FAIL sdone_res: got %h want %h", {bus.res_cout, bus.res_sum}, e);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; int acks; logic [1:0] g; logic [16:0] e;
    acks = 0;
    bus.a0 = 16'h5555; bus.b0 = 16'h1111; bus.cin0 = 0; bus.req0 = 1;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    n_chk++;
    if ({bus.res_cout, bus.res_sum, bus.ack0, bus.ack1, bus.core_a} !== 23'd0) begin
      n_fail++; $display("FAIL rmid_clear: got res %h ack %b core_a %h want 0",
                         {bus.res_cout, bus.res_sum}, {bus.ack0, bus.ack1}, bus.core_a);
    end
    bus.req0 = 0;
    @(negedge clk);
    rst = 0;
    exp_last = 1;
    repeat (12) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) acks++;
    end
    n_chk++;
    if (acks !== 0) begin n_fail++; $display("FAIL rmid_noack: got %0d acks want 0", acks); end
    bus.a0 = 16'($urandom); bus.b0 = 16'($urandom); bus.cin0 = 1'($urandom);
    e = ref_add(bus.a0, bus.b0, bus.cin0);
    bus.req0 = 1;
    wait_ack(0, cyc, g);
    bus.req0 = 0;
    exp_last = 0;
    n_chk++;
    if (cyc !== 9 || g !== 2'b10) begin
      n_fail++; $display("FAIL rmid_reissue: got cyc %0d id %b want 9 10", cyc, g);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.res_cout, bus.res_sum} !== e) begin
      n_fail++; $display("FAIL rmid_res: got %h want %h", {bus.res_cout, bus.res_sum}, e);
    end
  endtask

  task automatic test_random();
    int cyc; logic [1:0] g; logic [1:0] rq; logic gid; logic [16:0] e;
    for (int it = 0; it < 24; it++) begin
      rq = 2'($urandom_range(1, 3));
      bus.a0 = 16'($urandom); bus.b0 = 16'($urandom); bus.cin0 = 1'($urandom);
      bus.a1 = 16'($urandom); bus.b1 = 16'($urandom); bus.cin1 = 1'($urandom);
      gid = (rq == 2'b11) ? ~exp_last : (rq == 2'b10);
      e = gid ? ref_add(bus.a1, bus.b1, bus.cin1)
              : ref_add(bus.a0, bus.b0, bus.cin0);
      bus.req0 = rq[0]; bus.req1 = rq[1];
      @(negedge clk);
      bus.req0 = 1'($urandom); bus.req1 = 0;
      bus.a0 = 16'($urandom); bus.b0 = 16'($urandom); bus.cin0 = 1'($urandom);
      bus.a1 = 16'($urandom); bus.b1 = 16'($urandom); bus.cin1 = 1'($urandom);
      @(negedge clk);
      bus.req0 = 0;
      wait_ack(2, cyc, g);
      exp_last = gid;
      n_chk++;
      if (cyc !== 9 || g !== (gid ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rand_ack[%0d]: got cyc %0d id %b want 9 id %0d",
                           it, cyc, g, gid);
      end
      @(negedge clk);
      n_chk++;
      if ({bus.res_cout, bus.res_sum} !== e) begin
        n_fail++; $display("FAIL rand_res[%0d]: got %h want %h",
                           it, {bus.res_cout, bus.res_sum}, e);
      end
      n_chk++;
      if ({bus.core_a, bus.core_b, bus.core_cin} !== 9'd0) begin
        n_fail++; $display("FAIL rand_core_idle[%0d]: got %h want 0",
                           it, {bus.core_a, bus.core_b, bus.core_cin});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single0();
    test_single1();
    test_back_to_back();
    test_scan_capt();
    test_scan_done();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
